// File: rtl/switch_bank_if.sv
// Bundles the switch pins and the debounced outputs of switch_bank.
// The slave side is the debouncer; the master side is whatever owns the raw pins and consumes the events.
`timescale 1ns/1ps
interface switch_bank_if #(
   parameter int CHANNELS = 4
);
   logic [CHANNELS-1:0] switch_in;
   logic [CHANNELS-1:0] switch_out;
   logic [CHANNELS-1:0] rise_pulse;
   logic [CHANNELS-1:0] fall_pulse;
   logic                tick;

   modport master (
      output switch_in,
      input  switch_out, rise_pulse, fall_pulse, tick
   );

   modport slave (
      input  switch_in,
      output switch_out, rise_pulse, fall_pulse, tick
   );
endinterface

// File: rtl/switch_bank.sv
// Multi-channel switch debouncer: per-channel synchroniser and stability counter driven by a shared
// sample tick, with level or toggle output and one-cycle press/release pulses.
`timescale 1ns/1ps
module switch_bank #(
   parameter int CHANNELS     = 4,
   parameter int DIV_COUNT    = 256,
   parameter int STABLE_TICKS = 16,
   parameter int SYNC_STAGES  = 2,
   parameter bit RESET_LEVEL  = 1'b0,
   parameter bit TOGGLE_MODE  = 1'b0
) (
   input  logic          sys_clock,
   input  logic          reset,
   switch_bank_if.slave  bus
);
   localparam int DIV_W = $clog2(DIV_COUNT);
   localparam int CNT_W = $clog2(STABLE_TICKS + 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_COUNT - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

   logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
   logic [CHANNELS-1:0] sync;
   logic [DIV_W-1:0]    pre_q;
   logic                tick;
   logic [CHANNELS-1:0] state_vec;
   logic [CHANNELS-1:0] rise_vec;
   logic [CHANNELS-1:0] fall_vec;
   logic [CHANNELS-1:0] out_vec;

   always_ff @(posedge sys_clock or posedge reset) begin
      if (reset) begin
         for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= {CHANNELS{RESET_LEVEL}};
      end else begin
         sync_q[0] <= bus.switch_in;
         for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      end
   end

   assign sync = sync_q[SYNC_STAGES-1];

   assign tick = (pre_q == DIV_LAST);

   always_ff @(posedge sys_clock or posedge reset) begin
      if (reset)     pre_q <= '0;
      else if (tick) pre_q <= '0;
      else           pre_q <= pre_q + DIV_W'(1);
   end

   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      logic             st_q;
      logic             rise_q;
      logic             fall_q;
      logic [CNT_W-1:0] cnt_q;
      logic             flip;

      // A flip needs STABLE_TICKS consecutive ticks that all saw the new level.
      assign flip = tick && (sync[g] != st_q) && (cnt_q == CNT_LAST);

      always_ff @(posedge sys_clock or posedge reset) begin
         if (reset) begin
            st_q   <= RESET_LEVEL;
            cnt_q  <= '0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
         end else begin
            rise_q <= flip &  sync[g];
            fall_q <= flip & ~sync[g];
            if (tick) begin
               if (sync[g] == st_q) begin
                  cnt_q <= '0;
               end else if (cnt_q == CNT_LAST) begin
                  st_q  <= sync[g];
                  cnt_q <= '0;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
         end
      end

      if (TOGGLE_MODE) begin : g_tog
         logic tog_q;
         always_ff @(posedge sys_clock or posedge reset) begin
            if (reset)                tog_q <= 1'b0;
            else if (flip & sync[g])  tog_q <= ~tog_q;
         end
         assign out_vec[g] = tog_q;
      end else begin : g_lvl
         assign out_vec[g] = st_q;
      end

      assign state_vec[g] = st_q;
      assign rise_vec[g]  = rise_q;
      assign fall_vec[g]  = fall_q;
   end

   assign bus.switch_out = out_vec;
   assign bus.rise_pulse = rise_vec;
   assign bus.fall_pulse = fall_vec;
   assign bus.tick       = tick;
endmodule

// File: tb/tb_switch_bank.sv
// Directed bench for switch_bank: three instances (level mode, toggle mode, reset level 1)
// with DIV_COUNT=4, STABLE_TICKS=3, SYNC_STAGES=2.
`timescale 1ns/1ps
module tb_switch_bank;
   localparam int CH = 4;

   logic sys_clock = 1'b0;
   logic reset     = 1'b1;
   always #5 sys_clock = ~sys_clock;

   switch_bank_if #(.CHANNELS(CH)) bus_a ();
   switch_bank_if #(.CHANNELS(CH)) bus_b ();
   switch_bank_if #(.CHANNELS(CH)) bus_c ();

   switch_bank #(.CHANNELS(CH), .DIV_COUNT(4), .STABLE_TICKS(3), .SYNC_STAGES(2),
                 .RESET_LEVEL(1'b0), .TOGGLE_MODE(1'b0))
      dut_a (.sys_clock(sys_clock), .reset(reset), .bus(bus_a));
   switch_bank #(.CHANNELS(CH), .DIV_COUNT(4), .STABLE_TICKS(3), .SYNC_STAGES(2),
                 .RESET_LEVEL(1'b0), .TOGGLE_MODE(1'b1))
      dut_b (.sys_clock(sys_clock), .reset(reset), .bus(bus_b));
   switch_bank #(.CHANNELS(CH), .DIV_COUNT(4), .STABLE_TICKS(3), .SYNC_STAGES(2),
                 .RESET_LEVEL(1'b1), .TOGGLE_MODE(1'b0))
      dut_c (.sys_clock(sys_clock), .reset(reset), .bus(bus_c));

   int total = 0;
   int bad   = 0;

   int sel = 0;
   logic [3:0] m_rise, m_fall, m_out;
   always_comb begin
      m_rise = bus_a.rise_pulse;
      m_fall = bus_a.fall_pulse;
      m_out  = bus_a.switch_out;
      case (sel)
         1: begin m_rise = bus_b.rise_pulse; m_fall = bus_b.fall_pulse; m_out = bus_b.switch_out; end
         2: begin m_rise = bus_c.rise_pulse; m_fall = bus_c.fall_pulse; m_out = bus_c.switch_out; end
         default: ;
      endcase
   end

   int first_rise, first_fall, first_out, n_rise, n_fall;
   logic [3:0] rise_val, fall_val, out_start;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge sys_clock);
      #1;
   endtask

   // Runs n cycles on the selected instance and records when pulses/output first appear.
   task automatic watch(input int n);
      out_start  = m_out;
      first_rise = -1; first_fall = -1; first_out = -1;
      n_rise = 0; n_fall = 0; rise_val = '0; fall_val = '0;
      for (int k = 1; k <= n; k++) begin
         step();
         if (m_rise != 4'b0) begin
            n_rise++;
            if (first_rise < 0) begin first_rise = k; rise_val = m_rise; end
         end
         if (m_fall != 4'b0) begin
            n_fall++;
            if (first_fall < 0) begin first_fall = k; fall_val = m_fall; end
         end
         if (first_out < 0 && m_out != out_start) first_out = k;
      end
   endtask

   function automatic logic in_win(input int x);
      return (x >= 11) && (x <= 14);
   endfunction

   // Asserts reset between edges, checks the asynchronous reset values, releases just after an edge.
   task automatic do_reset();
      bus_a.switch_in = 4'h0;
      bus_b.switch_in = 4'h0;
      bus_c.switch_in = 4'hf;
      reset = 1'b1;
      #1;
      check("rst_out_a",  {28'd0, bus_a.switch_out}, 32'h0);
      check("rst_pulse_a", {24'd0, bus_a.rise_pulse, bus_a.fall_pulse}, 32'h0);
      check("rst_out_b",  {28'd0, bus_b.switch_out}, 32'h0);
      check("rst_out_c",  {28'd0, bus_c.switch_out}, 32'hf);
      check("rst_tick_a", {31'd0, bus_a.tick}, 32'h0);
      step();
      reset = 1'b0;
   endtask

   logic [3:0] acc;
   int fall_total;
   logic exp_tog [3];

   initial begin
      bus_a.switch_in = 4'h0;
      bus_b.switch_in = 4'h0;
      bus_c.switch_in = 4'hf;
      step();

      // 1: clean press on channel 0
      sel = 0;
      do_reset();
      bus_a.switch_in = 4'b0001;
      watch(20);
      check("t1_rise_window", {31'd0, in_win(first_rise)}, 32'd1);
      check("t1_rise_val",    {28'd0, rise_val}, 32'h1);
      check("t1_rise_count",  n_rise, 32'd1);
      check("t1_out_aligned", first_out, first_rise);
      check("t1_out_final",   {28'd0, m_out}, 32'h1);
      check("t1_no_fall",     n_fall, 32'd0);

      // 2: glitch on channel 1; the 2-cycle gap is placed to cover a sample tick
      do_reset();
      step(); step();
      acc = '0;
      for (int i = 0; i < 14; i++) begin
         bus_a.switch_in[1] = (i < 6) || (i >= 8);
         step();
         acc = acc | m_rise | m_fall | m_out;
      end
      bus_a.switch_in = 4'h0;
      for (int i = 0; i < 20; i++) begin
         step();
         acc = acc | m_rise | m_fall | m_out;
      end
      check("t2_quiet", {28'd0, acc}, 32'h0);

      // 3: all channels press together, then release together
      do_reset();
      bus_a.switch_in = 4'hf;
      watch(20);
      check("t3_rise_window", {31'd0, in_win(first_rise)}, 32'd1);
      check("t3_rise_val",    {28'd0, rise_val}, 32'hf);
      check("t3_rise_count",  n_rise, 32'd1);
      check("t3_out_high",    {28'd0, m_out}, 32'hf);
      bus_a.switch_in = 4'h0;
      watch(20);
      check("t3_fall_window", {31'd0, in_win(first_fall)}, 32'd1);
      check("t3_fall_val",    {28'd0, fall_val}, 32'hf);
      check("t3_fall_count",  n_fall, 32'd1);
      check("t3_no_rise",     n_rise, 32'd0);
      check("t3_out_low",     {28'd0, m_out}, 32'h0);

      // 4: toggle mode, three presses on channel 2
      sel = 1;
      do_reset();
      exp_tog[0] = 1'b1; exp_tog[1] = 1'b0; exp_tog[2] = 1'b1;
      fall_total = 0;
      for (int p = 0; p < 3; p++) begin
         bus_b.switch_in = 4'b0100;
         watch(16);
         check($sformatf("t4_press%0d_out", p), {31'd0, m_out[2]}, {31'd0, exp_tog[p]});
         check($sformatf("t4_press%0d_rise", p), {28'd0, rise_val}, 32'h4);
         bus_b.switch_in = 4'b0000;
         watch(16);
         check($sformatf("t4_release%0d_hold", p), first_out, 32'hffff_ffff);
         fall_total += n_fall;
      end
      check("t4_fall_total", fall_total, 32'd3);

      // 5: reset in the middle of a pending count on channel 3
      sel = 0;
      do_reset();
      bus_a.switch_in = 4'b1000;
      repeat (9) step();
      reset = 1'b1;
      #1;
      check("t5_async_out",   {28'd0, bus_a.switch_out}, 32'h0);
      check("t5_async_pulse", {24'd0, bus_a.rise_pulse, bus_a.fall_pulse}, 32'h0);
      step();
      reset = 1'b0;
      watch(20);
      check("t5_out_window", {31'd0, in_win(first_out)}, 32'd1);
      check("t5_rise_val",   {28'd0, rise_val}, 32'h8);

      // 6: reset level 1 and prescaler phase; cycle 1 is the one right after release
      sel = 2;
      do_reset();
      for (int c = 1; c <= 12; c++) begin
         if (c > 1) step();
         check($sformatf("t6_tick_c%0d", c), {31'd0, bus_c.tick}, {31'd0, (c % 4) == 0});
      end
      watch(20);
      check("t6_out_stays", {28'd0, m_out}, 32'hf);
      check("t6_no_pulses", n_rise + n_fall, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
